// File: rtl/imm_gen_pkg.sv
// Shared types and the immediate decode function for the pipelined immediate generator.
// The decode always produces 64 bits; 32-bit datapaths truncate the sign-extended result.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_U     = 3'b010,
        IMM_ZIMM  = 3'b011,
        IMM_SHAMT = 3'b100,
        IMM_B     = 3'b101,
        IMM_J     = 3'b110,
        IMM_ILL   = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // instr[k] is instruction bit k+7; rv64 widens the shift amount to 6 bits
    function automatic logic [63:0] imm_decode(input logic [24:0] instr,
                                               input imm_src_e   src,
                                               input logic       rv64);
        logic [63:0] imm;
        imm = '0;
        case (src)
            IMM_I:     imm = {{52{instr[24]}}, instr[24:13]};
            IMM_S:     imm = {{52{instr[24]}}, instr[24:18], instr[4:0]};
            IMM_B:     imm = {{51{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_U:     imm = {{32{instr[24]}}, instr[24:5], 12'b0};
            IMM_J:     imm = {{43{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
            IMM_ZIMM:  imm = {59'b0, instr[12:8]};
            IMM_SHAMT: imm = rv64 ? {58'b0, instr[18:13]} : {59'b0, instr[17:13]};
            default:   imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic two-entry skid buffer: a main register driving the outputs plus one skid entry.
// Ready is decoded from the state register only, so there is no path from i_ready to o_ready.
//
// state    | meaning
// ST_EMPTY | nothing held, o_valid=0
// ST_ONE   | main entry valid
// ST_TWO   | main and skid valid, upstream stalled
module imm_skid_buf
    import imm_gen_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    skid_state_e r_state;
    skid_state_e w_state_nxt;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic w_accept;
    logic w_pop;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;

    assign w_accept = i_valid && o_ready;
    assign w_pop    = o_valid && i_ready;
    assign o_data   = r_main;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_accept && !w_pop)      w_state_nxt = ST_TWO;
                else if (!w_accept && w_pop) w_state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (w_pop) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        o_valid        = (r_state != ST_EMPTY);
        o_ready        = (r_state != ST_TWO);
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: w_ld_main_in = w_accept;
            ST_ONE: begin
                w_ld_main_in = w_accept && w_pop;
                w_ld_skid    = w_accept && !w_pop;
            end
            ST_TWO:   w_ld_main_skid = w_pop;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_in)        r_main <= i_data;
            else if (w_ld_main_skid) r_main <= r_skid;
            if (w_ld_skid)           r_skid <= i_data;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on the input side, registered through a skid buffer.
// Optional transfer/error counters are enabled with IMM_GEN_STATS_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic            fmt_err
`ifdef IMM_GEN_STATS_EN
    ,
    output logic [31:0]     stat_xfers,
    output logic [15:0]     stat_errs
`endif
);

    localparam int SHW = (XLEN == 64) ? 6 : 5;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    imm_src_e        w_src;
    logic [XLEN-1:0] w_imm;
    logic            w_err;
    logic [XLEN:0]   w_out_data;

    assign w_src = imm_src_e'(imm_src);
    assign w_imm = XLEN'(imm_decode(instr, w_src, SHW == 6));
    assign w_err = (w_src == IMM_ILL);

    imm_skid_buf #(
        .W(XLEN + 1)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({w_err, w_imm}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_data)
    );

    assign imm_ext = w_out_data[XLEN-1:0];
    assign fmt_err = w_out_data[XLEN];

`ifdef IMM_GEN_STATS_EN
    logic        w_out_xfer;
    logic [31:0] r_stat_xfers;
    logic [15:0] r_stat_errs;

    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_xfers <= '0;
            r_stat_errs  <= '0;
        end else if (w_out_xfer) begin
            if (r_stat_xfers != '1)           r_stat_xfers <= r_stat_xfers + 32'd1;
            if (fmt_err && r_stat_errs != '1) r_stat_errs  <= r_stat_errs + 16'd1;
        end
    end

    assign stat_xfers = r_stat_xfers;
    assign stat_errs  = r_stat_errs;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input stream.
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] raw;
        logic [2:0]  src;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [24:0] instr;
    logic [2:0]  imm_src;
    logic        out_ready;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
`ifdef IMM_GEN_STATS_EN
    logic [31:0] xfers32, xfers64;
    logic [15:0] errs32, errs64;
`endif

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[9];

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid32),
        .out_ready(out_ready), .imm_ext(imm32), .fmt_err(err32)
`ifdef IMM_GEN_STATS_EN
        , .stat_xfers(xfers32), .stat_errs(errs32)
`endif
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_src(imm_src), .out_valid(out_valid64),
        .out_ready(out_ready), .imm_ext(imm64), .fmt_err(err64)
`ifdef IMM_GEN_STATS_EN
        , .stat_xfers(xfers64), .stat_errs(errs64)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        instr    = v.raw[31:7];
        imm_src  = v.src;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        chk({tag, "_v32"},   {63'b0, out_valid32}, 64'd1);
        chk({tag, "_imm32"}, {32'b0, imm32},       {32'b0, v.e32});
        chk({tag, "_err32"}, {63'b0, err32},       {63'b0, v.err});
        chk({tag, "_v64"},   {63'b0, out_valid64}, 64'd1);
        chk({tag, "_imm64"}, imm64,                v.e64);
        chk({tag, "_err64"}, {63'b0, err64},       {63'b0, v.err});
    endtask

    initial begin
        vecs[0] = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1] = '{32'hFE20AE23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[2] = '{32'h00208863, 3'b101, 32'h00000010, 64'h0000000000000010, 1'b0};
        vecs[3] = '{32'h001000EF, 3'b110, 32'h00000800, 64'h0000000000000800, 1'b0};
        vecs[4] = '{32'hFFDFF0EF, 3'b110, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[5] = '{32'h800002B7, 3'b010, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[6] = '{32'h03F0D093, 3'b100, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[7] = '{32'h3401D073, 3'b011, 32'h00000003, 64'h0000000000000003, 1'b0};
        vecs[8] = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = '0;
        imm_src   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid",  {63'b0, out_valid32}, 64'd0);
        chk("rst_ready",  {63'b0, in_ready32},  64'd1);
        chk("rst_imm",    {32'b0, imm32},       64'd0);
        chk("rst_err",    {63'b0, err32},       64'd0);
        chk("rst_imm64",  imm64,                64'd0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back stream, one result per cycle
        @(negedge clk);
        drive(vecs[0]);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check_out($sformatf("vec%0d", i - 1), vecs[i - 1]);
            chk($sformatf("stream_rdy%0d", i - 1), {63'b0, in_ready32}, 64'd1);
            if (i < 9) drive(vecs[i]);
            else       in_valid = 1'b0;
        end
        @(negedge clk);
        chk("stream_drain", {63'b0, out_valid32}, 64'd0);
`ifdef IMM_GEN_STATS_EN
        chk("stat_xfers", {32'b0, xfers32}, 64'd9);
        chk("stat_errs",  {48'b0, errs32},  64'd1);
`endif

        // backpressure: A, B accepted, C held off until downstream drains
        out_ready = 1'b0;
        drive(vecs[0]);
        @(negedge clk);
        chk("bp_rdy_a", {63'b0, in_ready32}, 64'd1);
        check_out("bp_a0", vecs[0]);
        drive(vecs[2]);
        @(negedge clk);
        chk("bp_rdy_b",   {63'b0, in_ready32}, 64'd0);
        chk("bp_rdy_b64", {63'b0, in_ready64}, 64'd0);
        check_out("bp_a1", vecs[0]);
        drive(vecs[3]);
        @(negedge clk);
        chk("bp_rdy_c", {63'b0, in_ready32}, 64'd0);
        check_out("bp_a2", vecs[0]);
        out_ready = 1'b1;
        @(negedge clk);
        check_out("bp_b", vecs[2]);
        chk("bp_rdy_pop", {63'b0, in_ready32}, 64'd1);
        @(negedge clk);
        check_out("bp_c", vecs[3]);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain", {63'b0, out_valid32}, 64'd0);

        // asynchronous reset while holding two entries
        out_ready = 1'b0;
        drive(vecs[0]);
        @(negedge clk);
        drive(vecs[2]);
        @(negedge clk);
        chk("mid_two", {63'b0, in_ready32}, 64'd0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {63'b0, out_valid32}, 64'd0);
        chk("mid_rst_ready", {63'b0, in_ready32},  64'd1);
        chk("mid_rst_imm",   {32'b0, imm32},       64'd0);
        chk("mid_rst_v64",   {63'b0, out_valid64}, 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(vecs[6]);
        @(negedge clk);
        check_out("post_rst", vecs[6]);
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_drain", {63'b0, out_valid32}, 64'd0);
        chk("post_rst_drain64", {63'b0, out_valid64}, 64'd0);
`ifdef IMM_GEN_STATS_EN
        chk("stat_post_rst", {32'b0, xfers32}, 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
